counter: RTL and testbench
==========================

# counter

Modulo-M enable-gated counter with a single-cycle carry-out pulse. It advances only on cycles where the enable input is high, and flags the enabled cycle on which it wraps from M-1 to 0. In the decimator path it counts accepted input samples (enable = input handshake) and fires `co` once every M samples to launch an output word.

## Interface
- `M`, default 10: modulus; count sequence 0..M-1; legal range M ≥ 1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `en`  input  1  count enable; counter advances on each rising edge where `en`=1.
- `co`  output  1  carry-out: `en` & (`cnt` == M-1), combinational, same cycle as the wrapping enable.
- `cnt`  output  W  current count, W = max(1, $clog2(M)); last port, may be left unconnected.

## Operation
- State: one register `cnt`, W bits, unsigned.
- Reset (`rst_n`=0, asynchronous assert, release synchronous to `clk`): `cnt`=0 immediately; `co`=0 while in reset regardless of `en`.
- `en`=0: `cnt` holds; `co`=0.
- `en`=1 and `cnt` < M-1: `cnt` ← `cnt`+1 next edge; `co`=0.
- `en`=1 and `cnt` == M-1: `cnt` ← 0 next edge; `co`=1 this cycle.
- M=1: `cnt` constant 0; `co` = `en` (out of reset).
- `cnt` never takes values ≥ M; no saturation or overflow mode.
- No output registers; `co` is a Mealy output of `cnt` and `en`.

## Timing
- `co` has zero latency relative to the M-th enabled cycle since reset or since the previous wrap; consumers sample it on the same edge that wraps `cnt`.
- Exactly one `co` pulse per M enabled cycles; idle (`en`=0) cycles between enables are ignored.
- `co` is high for exactly one cycle per wrap, except when M=1 with `en` held high (high every cycle).
- Reset asserted mid-count: `cnt` clears asynchronously; the partial count is discarded; the first `co` after release follows M further enables.
- `en` high in the cycle of reset release: the first rising edge with `rst_n`=1 counts.

## Configuration
- `COUNTER_ASSERT_EN` defined: bind-free inline SVA compiled in, disabled during reset:
  - `cnt` < M at every edge.
  - `co` implies `en`.
  - `co` implies `cnt` == 0 on the next edge.
  - A `co` pulse is followed by no other `co` until M enables have been counted.
- Not defined: no assertions; RTL behaviour identical.

## Structure
- Shared package `counter_pkg`:
  - function `cnt_width(M)` returning max(1, $clog2(M)).
  - localparam-style constant for the default modulus.
- Single flat module; no sub-module is warranted.

## Test plan
- M=5, `en` held 1 from reset release → `cnt` 0,1,2,3,4,0,…; `co`=1 exactly when `cnt`=4, i.e. every 5th cycle.
- M=5, `en` toggling 1,0,1,0,… → `co` on the 5th enabled cycle (cycle 9 after release); `cnt` holds across `en`=0 cycles.
- M=5, count to 3, assert `rst_n`=0 asynchronously between edges → `cnt`=0 immediately; after release, 5 more enables are needed for `co`.
- M=1, `en` = 1,1,0,1 → `co` = 1,1,0,1; `cnt` stays 0.
- M=8 (W=3), 20 consecutive enables → `co` at the 8th and 16th enables; `cnt` never exceeds 7.
- M=5, `en`=0 for 50 cycles after reset → `co` never asserts; `cnt` stays 0.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared definitions for the modulo-M counter.
//   - COUNTER_DEFAULT_M : default modulus
//   - cnt_width(m)      : count register width, max(1, $clog2(m))
package counter_pkg;

    localparam int COUNTER_DEFAULT_M = 10;

    // A modulus of 1 still needs a one-bit register to drive the cnt port.
    function automatic int cnt_width(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/counter.sv
// counter
//   Modulo-M enable-gated counter with a combinational carry-out pulse.
//   The count advances on every rising edge with en=1, wrapping from M-1
//   to 0. co flags the enabled cycle that causes the wrap, so a consumer
//   samples it on the same edge that returns cnt to 0.
//
//   Parameters:
//     M      modulus (M >= 1), count sequence 0..M-1
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (release synchronous to clk)
//     en     count enable
//     co     carry-out, en & (cnt == M-1), forced low during reset
//     cnt    current count, cnt_width(M) bits
//
//   Build option:
//     COUNTER_ASSERT_EN  compiles in inline SVA checks (disabled in reset).
module counter
    import counter_pkg::*;
#(
    parameter int M = COUNTER_DEFAULT_M
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    co,
    output logic [cnt_width(M)-1:0] cnt
);

    localparam int W = cnt_width(M);
    localparam logic [W-1:0] LAST = W'(M - 1);

    logic at_last;

    assign at_last = (cnt == LAST);

    // For M=1 the register stays at 0 because LAST is 0 and wraps every time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + W'(1);
        end
    end

    // rst_n is part of the term so co stays low in reset even when M=1,
    // where cnt already equals the last value.
    assign co = rst_n & en & at_last;

`ifdef COUNTER_ASSERT_EN
    // Independent count of enables since the last carry, used to check
    // carry spacing without relying on cnt itself.
    int en_since_co;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_since_co <= 0;
        end else if (co) begin
            en_since_co <= 0;
        end else if (en) begin
            en_since_co <= en_since_co + 1;
        end
    end

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= LAST);

    a_co_needs_en: assert property (@(posedge clk) disable iff (!rst_n)
        co |-> en);

    a_co_wraps: assert property (@(posedge clk) disable iff (!rst_n)
        co |=> (cnt == '0));

    a_co_spacing: assert property (@(posedge clk) disable iff (!rst_n)
        co |-> (en_since_co == M - 1));
`endif

endmodule

// File: tb/tb_counter.sv
// tb_counter
//   Directed bench for counter with three instances: M=5, M=1 and M=8.
//   Inputs change 1 ns after the rising edge; outputs are compared 3 ns
//   after the edge, well clear of the next one.
module tb_counter;

    logic       clk;
    logic       rst_n;
    logic       en5, en1, en8;
    logic       co5, co1, co8;
    logic [2:0] cnt5;
    logic [0:0] cnt1;
    logic [2:0] cnt8;

    int total  = 0;
    int passed = 0;

    counter #(.M(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .en(en5), .co(co5), .cnt(cnt5));
    counter #(.M(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .en(en1), .co(co1), .cnt(cnt1));
    counter #(.M(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .en(en8), .co(co8), .cnt(cnt8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset all instances; returns 1 ns after an edge with reset released,
    // so the following edge is the first one that can count.
    task automatic apply_reset();
        en5   = 1'b0;
        en1   = 1'b0;
        en8   = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en5   = 1'b1;
        en1   = 1'b1;
        en8   = 1'b1;
        #2;
        total++; if (cnt5 !== 3'd0) $display("FAIL reset_cnt5: got %0d expected 0", cnt5); else passed++;
        total++; if (cnt8 !== 3'd0) $display("FAIL reset_cnt8: got %0d expected 0", cnt8); else passed++;
        total++; if (co5 !== 1'b0)  $display("FAIL reset_co5: got %b expected 0", co5); else passed++;
        total++; if (co1 !== 1'b0)  $display("FAIL reset_co1_en_high: got %b expected 0", co1); else passed++;
        tick();
        tick();
        total++; if (cnt5 !== 3'd0) $display("FAIL reset_hold_cnt5: got %0d expected 0", cnt5); else passed++;
        total++; if (co1 !== 1'b0)  $display("FAIL reset_hold_co1: got %b expected 0", co1); else passed++;
        apply_reset();
    endtask

    task automatic test_en_held();
        int exp_cnt[11] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        bit exp_co[11]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            en5 = 1'b1;
            #2;
            total++; if (cnt5 !== 3'(exp_cnt[i])) $display("FAIL held_cnt[%0d]: got %0d expected %0d", i, cnt5, exp_cnt[i]); else passed++;
            total++; if (co5 !== exp_co[i]) $display("FAIL held_co[%0d]: got %b expected %b", i, co5, exp_co[i]); else passed++;
            tick();
        end
        en5 = 1'b0;
    endtask

    task automatic test_en_toggle();
        int exp_cnt[11] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};
        bit exp_co[11]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            en5 = (i % 2 == 0);
            #2;
            total++; if (cnt5 !== 3'(exp_cnt[i])) $display("FAIL toggle_cnt[%0d]: got %0d expected %0d", i, cnt5, exp_cnt[i]); else passed++;
            total++; if (co5 !== exp_co[i]) $display("FAIL toggle_co[%0d]: got %b expected %b", i, co5, exp_co[i]); else passed++;
            tick();
        end
        en5 = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        apply_reset();
        en5 = 1'b1;
        tick();
        tick();
        tick();
        en5 = 1'b0;
        #2;
        total++; if (cnt5 !== 3'd3) $display("FAIL mid_pre_cnt: got %0d expected 3", cnt5); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (cnt5 !== 3'd0) $display("FAIL mid_async_clear: got %0d expected 0", cnt5); else passed++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            en5 = 1'b1;
            #2;
            total++; if (cnt5 !== 3'(i)) $display("FAIL mid_after_cnt[%0d]: got %0d expected %0d", i, cnt5, i); else passed++;
            total++; if (co5 !== (i == 4)) $display("FAIL mid_after_co[%0d]: got %b expected %b", i, co5, (i == 4)); else passed++;
            tick();
        end
        en5 = 1'b0;
        #2;
        total++; if (cnt5 !== 3'd0) $display("FAIL mid_after_wrap: got %0d expected 0", cnt5); else passed++;
        tick();
    endtask

    task automatic test_m1();
        bit pat[4] = '{1, 1, 0, 1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            en1 = pat[i];
            #2;
            total++; if (co1 !== pat[i]) $display("FAIL m1_co[%0d]: got %b expected %b", i, co1, pat[i]); else passed++;
            total++; if (cnt1 !== 1'b0) $display("FAIL m1_cnt[%0d]: got %0d expected 0", i, cnt1); else passed++;
            tick();
        end
        en1 = 1'b0;
    endtask

    task automatic test_m8();
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            en8 = 1'b1;
            #2;
            if (co8 === 1'b1) pulses++;
            total++; if (cnt8 !== 3'(i % 8)) $display("FAIL m8_cnt[%0d]: got %0d expected %0d", i, cnt8, i % 8); else passed++;
            total++; if (co8 !== (i == 7 || i == 15)) $display("FAIL m8_co[%0d]: got %b expected %b", i, co8, (i == 7 || i == 15)); else passed++;
            tick();
        end
        en8 = 1'b0;
        total++; if (pulses != 2) $display("FAIL m8_pulse_count: got %0d expected 2", pulses); else passed++;
    endtask

    task automatic test_idle();
        int co_seen  = 0;
        int cnt_bad  = 0;
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            en5 = 1'b0;
            #2;
            if (co5 !== 1'b0) co_seen++;
            if (cnt5 !== 3'd0) cnt_bad++;
            tick();
        end
        total++; if (co_seen != 0) $display("FAIL idle_co: got %0d pulses expected 0", co_seen); else passed++;
        total++; if (cnt_bad != 0) $display("FAIL idle_cnt: got %0d nonzero cycles expected 0", cnt_bad); else passed++;
    endtask

    initial begin
        test_reset();
        test_en_held();
        test_en_toggle();
        test_reset_mid_count();
        test_m1();
        test_m8();
        test_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
